// File: rtl/edge_event_arbiter.sv
// Serialises one-cycle edge pulses from N_CH detectors into a single event stream.
// Each channel keeps one pending rising and one pending falling event; channels are served round-robin.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] ch_en,
    input  logic [N_CH-1:0] pos_edge,
    input  logic [N_CH-1:0] neg_edge,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_ch,
    output logic            evt_pol,
    output logic            evt_ovf,
    output logic            busy,
    output logic            dbg_state
);

    // Handshake: an event transfers on a rising clk edge where evt_valid && evt_ready;
    // while evt_valid=1 and evt_ready=0 the payload (evt_ch/evt_pol/evt_ovf) is held stable.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state;
    logic [N_CH-1:0] pend_pos, pend_neg, first, ovf;
    logic [ID_W-1:0] rr_ptr;

    logic [N_CH-1:0] req, gnt_pos, gnt_neg, pp, np;
    logic [N_CH-1:0] pend_pos_n, pend_neg_n, first_n, ovf_n;
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] gnt_ch;
    logic            free, gnt_any, gnt_ok, gnt_pol;

    always_comb begin
        req     = (pend_pos | pend_neg) & ch_en;
        free    = (state == EMPTY) || evt_ready;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (ID_W+1)'(rr_ptr) + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_CH))
                idx = idx - (ID_W+1)'(N_CH);
            if (!gnt_any && req[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_ch  = idx[ID_W-1:0];
            end
        end
        gnt_ok = free & gnt_any;
        // first=1 means the falling event is older, so the rising one goes second
        gnt_pol = (pend_pos[gnt_ch] & pend_neg[gnt_ch]) ? ~first[gnt_ch] : pend_pos[gnt_ch];
        gnt_pos = '0;
        gnt_neg = '0;
        if (gnt_ok) begin
            gnt_pos[gnt_ch] = gnt_pol;
            gnt_neg[gnt_ch] = ~gnt_pol;
        end
        // pp/np: pending bits that survive this cycle's grant; a pulse onto a survivor is lost
        pp         = pend_pos & ~gnt_pos;
        np         = pend_neg & ~gnt_neg;
        pend_pos_n = (pp | pos_edge) & ch_en;
        pend_neg_n = (np | neg_edge) & ch_en;
        first_n    = np & (~pp | first) & ch_en;
        ovf_n      = ((ovf & ~(gnt_pos | gnt_neg)) | (pos_edge & pp) | (neg_edge & np)) & ch_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            evt_ch   <= '0;
            evt_pol  <= 1'b0;
            evt_ovf  <= 1'b0;
            pend_pos <= '0;
            pend_neg <= '0;
            first    <= '0;
            ovf      <= '0;
            rr_ptr   <= '0;
        end else begin
            pend_pos <= pend_pos_n;
            pend_neg <= pend_neg_n;
            first    <= first_n;
            ovf      <= ovf_n;
            if (free) begin
                if (gnt_any) begin
                    state   <= FULL;
                    evt_ch  <= gnt_ch;
                    evt_pol <= gnt_pol;
                    evt_ovf <= ovf[gnt_ch];
                    rr_ptr  <= (gnt_ch == ID_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
                end else begin
                    state <= EMPTY;
                end
            end
        end
    end

    assign evt_valid = (state == FULL);
    assign dbg_state = state;
    assign busy      = (|pend_pos) | (|pend_neg) | evt_valid;

endmodule
